mdu: RTL and testbench

//  Iterative multiply/divide unit for EX stage; sits beside alu on the ID/EX operand bus (same A/B).

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_step.sv | 36 +++
 rtl/mdu.sv | 137 +++++++++++++
 tb/tb_mdu.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// MDUOp select codes and the mdu FSM state encoding.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDUOp_MULT  = 2'b00,
    MDUOp_MULTU = 2'b01,
    MDUOp_DIV   = 2'b10,
    MDUOp_DIVU  = 2'b11
  } mduop_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIN  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: mult add-shift or restoring div sub-shift.
// div=0: acc={partial,multiplier}; div=1: acc[W-1:0]=dividend/quotient, rem=partial remainder.
module mdu_step #(
  parameter int W = 32
) (
  input  logic           div,
  input  logic [W-1:0]   m,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   rem,
  output logic [2*W-1:0] acc_n,
  output logic [W-1:0]   rem_n
);

  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W-1:0] diff;
  logic         ok;

  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : '0);
    // 33-bit partial remainder: remainder shifted left, next dividend bit in
    sh    = {rem, acc[W-1]};
    ok    = sh >= {1'b0, m};
    // when ok the true difference is below m, so W bits hold it exactly
    diff  = sh[W-1:0] - m;
    acc_n = acc;
    rem_n = rem;
    if (div) begin
      rem_n = ok ? diff : sh[W-1:0];
      acc_n = {acc[2*W-1:W], acc[W-2:0], ok};
    end else begin
      acc_n = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Ports: clk, rst, start, MDUOp, A, B, hi_we, lo_we -> busy, done, HI, LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int W    = WIDTH;
  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(ITER);

  mdu_state_e state_q, state_d;

  logic [CW-1:0]  cnt_q;
  logic           div_q;
  logic           neg_q;
  logic           nega_q;
  logic           bz_q;
  logic [W-1:0]   m_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           done_q;

  logic           sgn;
  logic           sa;
  logic           sb;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [2*W-1:0] acc_n;
  logic [W-1:0]   rem_n;
  logic [2*W-1:0] prod;
  logic [W-1:0]   lo_div;
  logic [W-1:0]   hi_div;

  assign sgn = ~MDUOp[0];
  assign sa  = sgn & A[W-1];
  assign sb  = sgn & B[W-1];
  assign ma  = sa ? -A : A;
  assign mb  = sb ? -B : B;

  mdu_step #(.W(W)) u_step (
    .div  (div_q),
    .m    (m_q),
    .acc  (acc_q),
    .rem  (rem_q),
    .acc_n(acc_n),
    .rem_n(rem_n)
  );

  // divide by zero leaves quotient all ones; keep it unsigned
  assign prod   = neg_q ? -acc_q : acc_q;
  assign lo_div = (neg_q && !bz_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign hi_div = nega_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MDU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (start) state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == CW'(ITER - 1)) state_d = MDU_FIN;
      MDU_FIN:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
      bz_q   <= 1'b0;
      m_q    <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MDU_IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            div_q  <= MDUOp[1];
            neg_q  <= sa ^ sb;
            nega_q <= sa;
            bz_q   <= (B == '0);
            m_q    <= MDUOp[1] ? mb : ma;
            acc_q  <= {{W{1'b0}}, (MDUOp[1] ? ma : mb)};
            rem_q  <= '0;
          end else begin
            if (hi_we) hi_q <= A;
            if (lo_we) lo_q <= A;
          end
        end
        MDU_RUN: begin
          acc_q <= acc_n;
          rem_q <= rem_n;
          cnt_q <= cnt_q + 1'b1;
        end
        MDU_FIN: begin
          hi_q   <= div_q ? hi_div : prod[2*W-1:W];
          lo_q   <= div_q ? lo_div : prod[W-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors plus random ops vs model.
// Ports driven: clk, rst, start, MDUOp, A, B, hi_we, lo_we.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mdu #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .MDUOp(op),
    .A    (a),
    .B    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .busy (busy),
    .done (done),
    .HI   (hi),
    .LO   (lo)
  );

  always #5 clk = ~clk;

  function automatic void ref_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] eh,
    output logic [31:0] el
  );
    logic signed [63:0] sx, sy, p, q, r;
    logic [63:0] u;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin
        p  = sx * sy;
        eh = p[63:32];
        el = p[31:0];
      end
      2'd1: begin
        u  = {32'd0, x} * {32'd0, y};
        eh = u[63:32];
        el = u[31:0];
      end
      2'd2: begin
        if (y == 0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          el = q[31:0];
          eh = r[31:0];
        end
      end
      default: begin
        if (y == 0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // called at #1 after an edge; returns #1 after the accepting edge
  task automatic launch(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output int bcnt);
    int cyc;
    bcnt = 0;
    cyc  = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout got done=%b after %0d cycles exp done=1", done, cyc);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] xs  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] ys  [5] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehs [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'd0};
    logic [31:0] els [5] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int bc;
    for (int i = 0; i < 5; i++) begin
      launch(ops[i], xs[i], ys[i]);
      wait_done(bc);
      checks++;
      if (hi !== ehs[i] || lo !== els[i]) begin
        failures++;
        $display("FAIL directed%0d got hi=%h lo=%h exp hi=%h lo=%h", i, hi, lo, ehs[i], els[i]);
      end
      checks++;
      if (bc != 33 || busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_len%0d got %0d busy=%b exp 33 busy=0", i, bc, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse%0d got done=%b exp 0", i, done);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] eh, el, x, y;
    logic [1:0]  o;
    int bc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 9));
        3: x = 32'h8000_0000;
        default: ;
      endcase
      ref_op(o, x, y, eh, el);
      launch(o, x, y);
      hi_we = 1'b1;
      lo_we = 1'b1;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wait_done(bc);
      checks++;
      if (hi !== eh || lo !== el) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                 i, o, x, y, hi, lo, eh, el);
      end
    end
  endtask

  task automatic test_mtlo;
    int bc;
    int bad;
    lo_we = 1'b1;
    a     = 32'h1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h1234) begin
      failures++;
      $display("FAIL mtlo got lo=%h exp 00001234", lo);
    end
    hi_we = 1'b1;
    lo_we = 1'b1;
    a     = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_BABE || lo !== 32'hCAFE_BABE) begin
      failures++;
      $display("FAIL mthilo got hi=%h lo=%h exp cafebabe", hi, lo);
    end
    // start and lo_we together: start wins
    lo_we = 1'b1;
    launch(2'd1, 32'd2, 32'd3);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hCAFE_BABE || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_wins got lo=%h busy=%b exp cafebabe 1", lo, busy);
    end
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      lo_we = (i == 3);
      hi_we = (i == 4);
      a     = 32'h5555_5555;
      @(posedge clk);
      #1;
      if (done !== 1'b1 && (lo !== 32'hCAFE_BABE || hi !== 32'hCAFE_BABE)) bad++;
    end
    lo_we = 1'b0;
    hi_we = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_write got %0d disturbed cycles exp 0", bad);
    end
    wait_done(bc);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      failures++;
      $display("FAIL mult_after_mt got hi=%h lo=%h exp 0 6", hi, lo);
    end
  endtask

  task automatic test_busy_ignore;
    int bc;
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = 2'd1;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(bc);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000 || bc != 27) begin
      failures++;
      $display("FAIL busy_ignore got hi=%h lo=%h tail=%0d exp 0 80000000 27", hi, lo, bc);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] eh, el, x, y;
    int bc;
    x = $urandom;
    y = $urandom;
    ref_op(2'd0, x, y, eh, el);
    launch(2'd0, x, y);
    wait_done(bc);
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL b2b_first got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, eh, el);
    end
    x = $urandom;
    y = 32'($urandom_range(1, 1000));
    ref_op(2'd3, x, y, eh, el);
    launch(2'd3, x, y);
    wait_done(bc);
    checks++;
    if (hi !== eh || lo !== el || bc != 33) begin
      failures++;
      $display("FAIL b2b_second got hi=%h lo=%h busy=%0d exp hi=%h lo=%h 33",
               hi, lo, bc, eh, el);
    end
  endtask

  task automatic test_reset_midop;
    int pulses;
    launch(2'd3, 32'hFFFF_0000, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b hi=%h lo=%h done=%b exp 0", busy, hi, lo, done);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || lo !== 32'd0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_abort got %0d done/lo events exp 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
